// File: rtl/jt900h_idxaddr_if.sv
// Bus between the TLCS-900H indexed-address generator and its sequencer/register file.
// Everything except clock and reset travels through this interface.
interface jt900h_idxaddr_if;
  logic        cen;
  logic        start;
  logic [7:0]  mode;
  logic        busy;
  logic        byte_req;
  logic        byte_vld;
  logic [7:0]  byte_in;
  logic        idx_en;
  logic [7:0]  idx_rdreg_sel;
  logic [7:0]  idx_rdreg_aux;
  logic [1:0]  reg_step;
  logic        reg_inc;
  logic        reg_dec;
  logic [31:0] src_out;
  logic [31:0] dst_out;
  logic [23:0] addr;
  logic        addr_vld;
  logic        err;

  modport slave (
    input  cen, start, mode, byte_vld, byte_in, src_out, dst_out,
    output busy, byte_req, idx_en, idx_rdreg_sel, idx_rdreg_aux, reg_step, reg_inc, reg_dec,
           addr, addr_vld, err
  );

  modport master (
    output cen, start, mode, byte_vld, byte_in, src_out, dst_out,
    input  busy, byte_req, idx_en, idx_rdreg_sel, idx_rdreg_aux, reg_step, reg_inc, reg_dec,
           addr, addr_vld, err
  );
endinterface

// File: rtl/jt900h_idxaddr.sv
// TLCS-900H memory-operand effective-address generator: decodes the mode byte, gathers
// extension/offset bytes, reads registers for one cycle and emits a 24-bit address.
module jt900h_idxaddr (
  input logic            clk,
  input logic            rst,
  jt900h_idxaddr_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StExt, StOfs, StRd, StOut} state_e;
  typedef enum logic [3:0] {
    KBase, KD8, KImm, KExt, KPre, KPost, KD16, KR8, KR16
  } kind_e;

  state_e      state_q, state_d;
  kind_e       kind_q, kind_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [1:0]  last_q, last_d;
  logic [7:0]  reg_q, reg_d;
  logic [1:0]  step_q, step_d;
  logic [23:0] ofs_q, ofs_d;
  logic [23:0] addr_q, addr_d;
  logic        err_q, err_d;
  logic        byte_take;
  logic        in_rd, code_ofs;
  logic        unused_hi;

  assign unused_hi = ^{bus.src_out[31:24], bus.dst_out[31:24]};
  assign byte_take = bus.byte_req & bus.byte_vld;

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    reg_d   = reg_q;
    step_d  = step_q;
    ofs_d   = ofs_q;
    addr_d  = addr_q;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          ofs_d = '0;
          cnt_d = '0;
          if (bus.mode[7:6] == 2'b10) begin
            // Short register code: E0,E4,E8,EC then F0,F4,F8,FC.
            reg_d   = {3'b111, bus.mode[2:0], 2'b00};
            last_d  = 2'd0;
            kind_d  = bus.mode[3] ? KD8 : KBase;
            state_d = bus.mode[3] ? StOfs : StRd;
          end else if (bus.mode[7:6] == 2'b11) begin
            case (bus.mode[2:0])
              3'd0, 3'd1, 3'd2: begin
                kind_d  = KImm;
                last_d  = bus.mode[1:0];
                state_d = StOfs;
              end
              3'd3:    begin kind_d = KExt;  state_d = StExt; end
              3'd4:    begin kind_d = KPre;  state_d = StExt; end
              3'd5:    begin kind_d = KPost; state_d = StExt; end
              default: err_d = 1'b1;
            endcase
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StExt: begin
        if (byte_take) begin
          reg_d  = {bus.byte_in[7:2], 2'b00};
          step_d = bus.byte_in[1:0];
          last_d = 2'd1;
          if (kind_q == KExt) begin
            if (bus.byte_in[1:0] == 2'b00) begin
              kind_d = KBase; state_d = StRd;
            end else if (bus.byte_in[1:0] == 2'b01) begin
              kind_d = KD16;  state_d = StOfs;
            end else if (bus.byte_in == 8'h03) begin
              kind_d = KR8;   state_d = StOfs;
            end else if (bus.byte_in == 8'h07) begin
              kind_d = KR16;  state_d = StOfs;
            end else begin
              err_d = 1'b1;   state_d = StIdle;
            end
          end else if (bus.byte_in[1:0] == 2'b11) begin
            err_d = 1'b1; state_d = StIdle;
          end else begin
            state_d = StRd;
          end
        end
      end
      StOfs: begin
        if (byte_take) begin
          case (cnt_q)
            2'd0:    ofs_d[7:0]   = bus.byte_in;
            2'd1:    ofs_d[15:8]  = bus.byte_in;
            default: ofs_d[23:16] = bus.byte_in;
          endcase
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == last_q) begin
            if (kind_q == KImm) begin
              addr_d  = ofs_d;
              state_d = StOut;
            end else begin
              state_d = StRd;
            end
          end
        end
      end
      StRd: begin
        case (kind_q)
          KD8:     addr_d = bus.src_out[23:0] + {{16{ofs_q[7]}}, ofs_q[7:0]};
          KD16:    addr_d = bus.src_out[23:0] + {{8{ofs_q[15]}}, ofs_q[15:0]};
          KR8:     addr_d = bus.src_out[23:0] + {{16{bus.dst_out[7]}}, bus.dst_out[7:0]};
          KR16:    addr_d = bus.src_out[23:0] + {{8{bus.dst_out[15]}}, bus.dst_out[15:0]};
          KPre:    addr_d = bus.dst_out[23:0];
          default: addr_d = bus.src_out[23:0];
        endcase
        state_d = StOut;
      end
      StOut:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      kind_q  <= KBase;
      cnt_q   <= '0;
      last_q  <= '0;
      reg_q   <= '0;
      step_q  <= '0;
      ofs_q   <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else if (bus.cen) begin
      state_q <= state_d;
      kind_q  <= kind_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      reg_q   <= reg_d;
      step_q  <= step_d;
      ofs_q   <= ofs_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
    end
  end

  // Register-file strobes exist only in RD; (r32+r8/r16) take both codes from the operand bytes.
  assign in_rd    = (state_q == StRd);
  assign code_ofs = (kind_q == KR8) || (kind_q == KR16);

  always_comb begin
    bus.idx_rdreg_sel = '0;
    bus.idx_rdreg_aux = '0;
    bus.reg_step      = '0;
    if (in_rd) begin
      bus.idx_rdreg_sel = code_ofs ? ofs_q[7:0] : reg_q;
      if (code_ofs) begin
        bus.idx_rdreg_aux = ofs_q[15:8];
      end else if (kind_q == KPre || kind_q == KPost) begin
        bus.idx_rdreg_aux = reg_q;
        bus.reg_step      = step_q;
      end
    end
  end

  assign bus.busy     = (state_q != StIdle);
  assign bus.byte_req = (state_q == StExt) || (state_q == StOfs);
  assign bus.idx_en   = in_rd;
  assign bus.reg_inc  = in_rd && (kind_q == KPost);
  assign bus.reg_dec  = in_rd && (kind_q == KPre);
  assign bus.addr     = addr_q;
  assign bus.addr_vld = (state_q == StOut);
  assign bus.err      = err_q;

endmodule

// File: tb/tb_jt900h_idxaddr.sv
// Randomized self-checking bench for jt900h_idxaddr against a mode-level reference model.
module tb_jt900h_idxaddr;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  jt900h_idxaddr_if bus ();
  jt900h_idxaddr dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_errs   = 0;
  logic [23:0] last_addr = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    bit          err;
    int          nbytes;
    int          rd;
    bit          chk_sel;
    logic [7:0]  sel;
    bit          chk_aux;
    logic [7:0]  aux;
    logic [1:0]  step;
    bit          inc;
    bit          dec;
    logic [23:0] addr;
  } exp_t;

  function automatic logic [23:0] add24(input logic [31:0] base, input int ofs);
    logic [31:0] s;
    s = base + 32'(ofs);
    return s[23:0];
  endfunction

  function automatic int sx8(input logic [7:0] x);
    return int'($signed(x));
  endfunction

  function automatic int sx16(input logic [15:0] x);
    return int'($signed(x));
  endfunction

  // Expected outcome of one addressing sequence, derived from the mode rules directly.
  function automatic exp_t model(input logic [7:0] mode, input logic [7:0] b0, b1, b2,
                                 input logic [31:0] src, dst);
    exp_t e;
    int   r, m;
    e = '{err: 0, nbytes: 0, rd: 0, chk_sel: 0, sel: 0, chk_aux: 0, aux: 0, step: 0,
          inc: 0, dec: 0, addr: last_addr};
    m = int'(mode[2:0]);
    if (mode[7:6] == 2'b10) begin
      r = int'(mode[2:0]);
      e.rd = 1; e.chk_sel = 1;
      e.sel = (r < 4) ? 8'(8'hE0 + 4 * r) : 8'(8'hF0 + 4 * (r - 4));
      if (mode[3]) begin e.nbytes = 1; e.addr = add24(src, sx8(b0)); end
      else         e.addr = src[23:0];
    end else if (mode[7:6] == 2'b11 && m <= 2) begin
      e.nbytes = m + 1;
      e.addr = 24'(int'(b0) + (m >= 1 ? int'(b1) * 256 : 0) + (m == 2 ? int'(b2) * 65536 : 0));
    end else if (mode[7:6] == 2'b11 && m == 3) begin
      e.nbytes = 1; e.rd = 1; e.chk_sel = 1; e.sel = b0 & 8'hFC;
      if (b0[1:0] == 2'b00) e.addr = src[23:0];
      else if (b0[1:0] == 2'b01) begin e.nbytes = 3; e.addr = add24(src, sx16({b2, b1})); end
      else if (b0 == 8'h03 || b0 == 8'h07) begin
        e.nbytes = 3; e.sel = b1; e.chk_aux = 1; e.aux = b2;
        e.addr = (b0 == 8'h03) ? add24(src, sx8(dst[7:0])) : add24(src, sx16(dst[15:0]));
      end else begin
        e.err = 1; e.rd = 0; e.chk_sel = 0; e.addr = last_addr;
      end
    end else if (mode[7:6] == 2'b11 && (m == 4 || m == 5)) begin
      e.nbytes = 1;
      if (b0[1:0] == 2'b11) e.err = 1;
      else begin
        e.rd = 1; e.chk_aux = 1; e.aux = b0 & 8'hFC; e.step = b0[1:0];
        e.dec = (m == 4); e.inc = (m == 5);
        e.chk_sel = (m == 5); e.sel = b0 & 8'hFC;
        e.addr = (m == 4) ? dst[23:0] : src[23:0];
      end
    end else begin
      e.err = 1;
    end
    return e;
  endfunction

  task automatic run_txn(input logic [7:0] mode, b0, b1, b2, input logic [31:0] src, dst,
                         input bit rnd_cen, output logic [23:0] got);
    exp_t        e;
    logic [7:0]  bq [3];
    int          idx, rd_cnt, err_cnt;
    bit          done, cen_n, vld_n, busy_s, req_s, en_s, vld_s, err_s;
    logic [7:0]  sel_s, aux_s;
    logic [1:0]  step_s;
    bit          inc_s, dec_s;
    e = model(mode, b0, b1, b2, src, dst);
    bq[0] = b0; bq[1] = b1; bq[2] = b2;
    idx = 0; rd_cnt = 0; err_cnt = 0; done = 0; got = bus.addr;
    bus.src_out = src; bus.dst_out = dst;
    bus.start = 1'b1; bus.mode = mode; bus.cen = 1'b1; bus.byte_vld = 1'b0;
    @(negedge clk);
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      busy_s = bus.busy; req_s = bus.byte_req; en_s = bus.idx_en;
      vld_s = bus.addr_vld; err_s = bus.err; sel_s = bus.idx_rdreg_sel;
      aux_s = bus.idx_rdreg_aux; step_s = bus.reg_step; inc_s = bus.reg_inc; dec_s = bus.reg_dec;
      cen_n = rnd_cen ? ($urandom_range(0, 3) != 0) : 1'b1;
      vld_n = ($urandom_range(0, 2) != 0);
      bus.cen = cen_n; bus.byte_vld = vld_n;
      bus.byte_in = (idx < 3) ? bq[idx] : 8'($urandom);
      bus.start = busy_s && ($urandom_range(0, 3) == 0);
      bus.mode = 8'($urandom);
      if (cen_n) begin
        if (req_s && vld_n) idx++;
        if (en_s) begin
          rd_cnt++;
          if (e.chk_sel) check_eq("rd_sel", 32'(sel_s), 32'(e.sel));
          if (e.chk_aux) check_eq("rd_aux", 32'(aux_s), 32'(e.aux));
          check_eq("rd_step", 32'(step_s), 32'(e.chk_aux && !code_op(mode, b0) ? e.step : 2'd0));
          check_eq("rd_inc", 32'(inc_s), 32'(e.inc));
          check_eq("rd_dec", 32'(dec_s), 32'(e.dec));
        end
        if (vld_s) begin got = bus.addr; done = 1; end
        if (err_s) begin err_cnt++; done = 1; end
      end
      @(negedge clk);
    end
    bus.start = 1'b0; bus.cen = 1'b1; bus.byte_vld = 1'b0;
    check_eq("finished", 32'(done), 32'd1);
    check_eq("bytes_used", 32'(idx), 32'(e.nbytes));
    check_eq("rd_cycles", 32'(rd_cnt), 32'(e.rd));
    check_eq("err_seen", 32'(err_cnt), 32'(e.err));
    if (!e.err) check_eq("addr", 32'(got), 32'(e.addr));
    check_eq("addr_hold", 32'(bus.addr), 32'(e.addr));
    check_eq("idle_after", 32'({bus.busy, bus.addr_vld, bus.err}), 32'd0);
    last_addr = e.addr;
  endtask

  // Register-pair form of the extended mode, where step is not meaningful.
  function automatic bit code_op(input logic [7:0] mode, input logic [7:0] b0);
    return (mode[7:6] == 2'b11) && (mode[2:0] == 3'd3);
  endfunction

  logic [23:0] got;
  logic [7:0]  m, b0;
  int          seen;

  initial begin
    bus.cen = 1'b1; bus.start = 1'b0; bus.mode = '0; bus.byte_vld = 1'b0;
    bus.byte_in = '0; bus.src_out = '0; bus.dst_out = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_addr", 32'(bus.addr), 32'd0);
    check_eq("rst_flags", 32'({bus.busy, bus.addr_vld, bus.err, bus.byte_req, bus.idx_en,
                               bus.reg_inc, bus.reg_dec}), 32'd0);
    check_eq("rst_codes", 32'({bus.reg_step, bus.idx_rdreg_sel, bus.idx_rdreg_aux}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_txn(8'h83, 8'h00, 8'h00, 8'h00, 32'h0012_3456, 32'h0, 1'b0, got);
    check_eq("dir_r", 32'(got), 32'h12_3456);
    run_txn(8'hC2, 8'h56, 8'h34, 8'h12, 32'hDEAD_BEEF, 32'h0, 1'b0, got);
    check_eq("dir_imm24", 32'(got), 32'h12_3456);
    run_txn(8'h8C, 8'hFE, 8'h00, 8'h00, 32'h0000_1000, 32'h0, 1'b0, got);
    check_eq("dir_d8", 32'(got), 32'h00_0FFE);
    run_txn(8'hC4, 8'hF6, 8'h00, 8'h00, 32'h0, 32'h0000_01FC, 1'b0, got);
    check_eq("dir_predec", 32'(got), 32'h00_01FC);
    run_txn(8'hC3, 8'h07, 8'hE0, 8'hE4, 32'h0000_8000, 32'h0000_FFF0, 1'b0, got);
    check_eq("dir_r16", 32'(got), 32'h00_7FF0);
    run_txn(8'hC6, 8'h00, 8'h00, 8'h00, 32'h0, 32'h0, 1'b0, got);

    // Asynchronous reset in the middle of an immediate fetch.
    bus.start = 1'b1; bus.mode = 8'hC2;
    @(negedge clk);
    bus.start = 1'b0; bus.byte_vld = 1'b1; bus.byte_in = 8'h56;
    @(negedge clk);
    bus.byte_vld = 1'b0;
    check_eq("ofs_busy", 32'(bus.busy), 32'd1);
    #2 rst = 1'b1;
    #1 check_eq("rst_abort", 32'({bus.busy, bus.byte_req, bus.reg_inc, bus.reg_dec}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    bus.byte_vld = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.addr_vld || bus.busy) seen++;
    end
    bus.byte_vld = 1'b0;
    check_eq("rst_no_vld", 32'(seen), 32'd0);
    check_eq("rst_addr0", 32'(bus.addr), 32'd0);
    last_addr = '0;

    for (int t = 0; t < 200; t++) begin
      m  = 8'($urandom);
      b0 = 8'($urandom);
      case ($urandom_range(0, 5))
        0: m[7:6] = 2'b10;
        1: begin m[7:6] = 2'b11; m[2:0] = 3'($urandom_range(0, 2)); end
        2: begin
          m[7:6] = 2'b11; m[2:0] = 3'd3;
          case ($urandom_range(0, 4))
            0: b0[1:0] = 2'b00;
            1: b0[1:0] = 2'b01;
            2: b0 = 8'h03;
            3: b0 = 8'h07;
            default: ;
          endcase
        end
        3: begin m[7:6] = 2'b11; m[2:0] = 3'd4; end
        4: begin m[7:6] = 2'b11; m[2:0] = 3'd5; end
        default: ;
      endcase
      run_txn(m, b0, 8'($urandom), 8'($urandom), $urandom, $urandom, 1'b1, got);
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
